ps2_host_tx: RTL

Host-to-device PS/2 command transmitter on the FPGA side of the PS2_CLK1/PS2_DATA1 mouse link. It sends one command byte (e.g. 0xF4 Enable Data Reporting, 0xFF Reset) using request-to-send: clock inhibit, start bit, 8 data bits LSB first, odd parity, stop, then device ACK. It drives the lines open-drain through output-enable pins; the top level builds the inout pads. It sits beside the existing PS/2 receive path, which must ignore the bus while `busy`=1.

---
 rtl/ps2_pkg.sv | 32 +++
 rtl/ps2_sync_filter.sv | 74 +++++++
 rtl/ps2_host_tx.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state encoding, error codes, 50 MHz timing defaults
// and the parity helper. Imported by both the host transmitter and the receive path.
package ps2_pkg;

    // Host transmitter states
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQ       = 3'd2,
        XFER      = 3'd3,
        WAIT_IDLE = 3'd4
    } ps2_state_e;

    // err_code values reported alongside tx_err
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_NACK    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // Timing defaults for a 50 MHz system clock
    localparam int unsigned INHIBIT_CYCLES_50M = 5000;    // 100 us clock inhibit
    localparam int unsigned TIMEOUT_CYCLES_50M = 750000;  // 15 ms release-to-ACK limit
    localparam int unsigned FILTER_LEN_50M     = 8;

    // Width of the transfer timeout counter; must hold TIMEOUT_CYCLES
    localparam int unsigned TMO_W = 20;

    // Odd parity: the 9-bit word {par, data} always carries an odd number of ones
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// PS/2 pin conditioning: 2-flop synchronizer, optional glitch filter that accepts a
// new level only after FILTER_LEN consecutive equal samples, and a one-cycle pulse
// on every accepted 1->0 transition. BYPASS=1 keeps only the synchronizer.
module ps2_sync_filter #(
    parameter int unsigned FILTER_LEN = 8,
    parameter bit          BYPASS     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic fall
);

    localparam int unsigned      CW   = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0]    LAST = CW'(FILTER_LEN - 1);

    logic [1:0] sync_q;
    logic       sync_s;

    // Two-stage synchronizer; resets to the idle (high) bus level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], pin};
        end
    end

    assign sync_s = sync_q[1];

    if (BYPASS) begin : g_bypass
        logic prev_q;

        // Previous synchronized level for edge detection
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                prev_q <= 1'b1;
            end else begin
                prev_q <= sync_s;
            end
        end

        assign level = sync_s;
        assign fall  = prev_q & ~sync_s;
    end else begin : g_filter
        logic [CW-1:0] cnt_q;
        logic          level_q;
        logic          fall_q;

        // Count consecutive samples that disagree with the accepted level
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q   <= '0;
                level_q <= 1'b1;
                fall_q  <= 1'b0;
            end else if (sync_s == level_q) begin
                cnt_q  <= '0;
                fall_q <= 1'b0;
            end else if (cnt_q == LAST) begin
                cnt_q   <= '0;
                level_q <= sync_s;
                fall_q  <= ~sync_s;
            end else begin
                cnt_q  <= cnt_q + CW'(1);
                fall_q <= 1'b0;
            end
        end

        assign level = level_q;
        assign fall  = fall_q;
    end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter. Performs request-to-send (clock inhibit,
// start bit), shifts one byte LSB first with odd parity and stop bit on the
// device-generated clock, then checks the device ACK. Lines are driven open-drain
// through the *_oe outputs; the pads live in the level above.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = INHIBIT_CYCLES_50M,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_50M,
    parameter int unsigned FILTER_LEN     = FILTER_LEN_50M
) (
    input  logic       CLK_50M,
    input  logic       RST,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err,
    output logic [1:0] err_code,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int unsigned       INH_W     = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [INH_W-1:0]  INH_LAST  = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);
    // Falls are numbered from 1; the 11th (bit_cnt already 10) carries the ACK
    localparam logic [3:0]        ACK_IDX   = 4'd10;

    ps2_state_e        state_q, state_d;
    logic [7:0]        byte_q;
    logic              par_q;
    logic [INH_W-1:0]  inh_cnt_q;
    logic [3:0]        bit_cnt_q;
    logic [TMO_W-1:0]  tmo_cnt_q;
    logic              data_oe_q;
    logic [1:0]        err_code_q;

    logic clk_s;
    logic clk_fall;
    logic data_s;
    logic data_fall_unused;

    logic accept;
    logic inh_done;
    logic tmo_hit;
    logic ack_fall;
    logic nack;
    logic line_idle;

    ps2_sync_filter #(
        .FILTER_LEN (FILTER_LEN),
        .BYPASS     (1'b0)
    ) u_clk_filter (
        .clk   (CLK_50M),
        .rst   (RST),
        .pin   (ps2_clk_in),
        .level (clk_s),
        .fall  (clk_fall)
    );

    ps2_sync_filter #(
        .FILTER_LEN (FILTER_LEN),
        .BYPASS     (1'b1)
    ) u_data_sync (
        .clk   (CLK_50M),
        .rst   (RST),
        .pin   (ps2_data_in),
        .level (data_s),
        .fall  (data_fall_unused)
    );

    assign accept    = tx_valid && (state_q == IDLE);
    assign inh_done  = (state_q == INHIBIT) && (inh_cnt_q == INH_LAST);
    assign tmo_hit   = ((state_q == XFER) || (state_q == WAIT_IDLE)) && (tmo_cnt_q == TMO_LIMIT);
    assign ack_fall  = (state_q == XFER) && clk_fall && (bit_cnt_q == ACK_IDX);
    // Timeout takes priority over a coincident ACK-slot fall
    assign nack      = ack_fall && data_s && !tmo_hit;
    assign line_idle = clk_s && data_s;

    // State register
    always_ff @(posedge CLK_50M or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = INHIBIT;
            end
            INHIBIT: begin
                if (inh_done) state_d = REQ;
            end
            REQ: begin
                state_d = XFER;
            end
            XFER: begin
                if (tmo_hit) begin
                    state_d = IDLE;
                end else if (ack_fall) begin
                    state_d = data_s ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (tmo_hit || line_idle) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: line enables from state, completion/abort pulses in the deciding cycle
    always_comb begin
        tx_ready    = (state_q == IDLE);
        busy        = (state_q != IDLE);
        ps2_clk_oe  = (state_q == INHIBIT) || (state_q == REQ);
        ps2_data_oe = (state_q == REQ) || ((state_q == XFER) && data_oe_q);
        tx_done     = (state_q == WAIT_IDLE) && line_idle && !tmo_hit;
        tx_err      = tmo_hit || nack;
        err_code    = err_code_q;
        if (tmo_hit) begin
            err_code = ERR_TIMEOUT;
        end else if (nack) begin
            err_code = ERR_NACK;
        end
    end

    // Datapath: command latch, inhibit/bit/timeout counters, data line enable
    always_ff @(posedge CLK_50M or posedge RST) begin
        if (RST) begin
            byte_q     <= '0;
            par_q      <= 1'b0;
            inh_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
            data_oe_q  <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            err_code_q <= err_code;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        byte_q    <= tx_data;
                        par_q     <= odd_parity(tx_data);
                        inh_cnt_q <= '0;
                    end
                end
                INHIBIT: begin
                    inh_cnt_q <= inh_cnt_q + INH_W'(1);
                end
                REQ: begin
                    bit_cnt_q <= '0;
                    tmo_cnt_q <= '0;
                    // Start bit stays on the line until the device's first fall
                    data_oe_q <= 1'b1;
                end
                XFER: begin
                    tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                    if (clk_fall) begin
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q < 4'd8) begin
                            data_oe_q <= ~byte_q[bit_cnt_q[2:0]];
                        end else if (bit_cnt_q == 4'd8) begin
                            data_oe_q <= ~par_q;
                        end else if (bit_cnt_q == 4'd9) begin
                            data_oe_q <= 1'b0;
                        end
                    end
                end
                WAIT_IDLE: begin
                    tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
